// File: rtl/mips_chk_pkg.sv
// Shared types and default parameters for the MIPS result checker.
// The table entry is sized to the 8-bit core bus.
package mips_chk_pkg;

    localparam int CHK_WIDTH   = 8;
    localparam int CHK_NCHK    = 4;
    localparam int CHK_TIMEOUT = 1000;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL,
        TOUT
    } chk_state_t;

    typedef struct packed {
        logic [CHK_WIDTH-1:0] adr;
        logic [CHK_WIDTH-1:0] data;
        logic                 valid;
    } chk_entry_t;

endpackage

// File: rtl/mips_chk_table.sv
// Expected-write register file: one-cycle synchronous write and a combinational read at the pointer.
// The valid bits of the pointer entry's successor and of entry 0 are exposed for end-of-list and start decisions.
module mips_chk_table
    import mips_chk_pkg::*;
#(
    parameter int NCHK = CHK_NCHK,
    parameter int IW   = 2
)(
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  chk_entry_t    wentry_i,
    input  logic [IW-1:0] rptr_i,
    output chk_entry_t    rentry_o,
    output logic          nxt_valid_o,
    output logic          head_valid_o
);

    chk_entry_t    entries_q [NCHK];
    logic [IW-1:0] nxt_idx;

    // Only the valid bits need a reset; address/data are don't-care while invalid.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NCHK; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else if (we_i && (int'(widx_i) < NCHK)) begin
            entries_q[widx_i] <= wentry_i;
        end
    end

    assign rentry_o     = entries_q[rptr_i];
    assign head_valid_o = entries_q[0].valid;
    assign nxt_idx      = rptr_i + 1'b1;

    always_comb begin
        nxt_valid_o = 1'b0;
        if (int'(rptr_i) < NCHK - 1) begin
            nxt_valid_o = entries_q[nxt_idx].valid;
        end
    end

endmodule

// File: rtl/mips_result_checker.sv
// Memory-write monitor comparing core stores against an ordered expected table; flags are registered, one cycle after the deciding write.
// Never stalls the core. MIPS_CHK_TIMEOUT_EN adds the run timer, TOUT state and timeout flag.
module mips_result_checker
    import mips_chk_pkg::*;
#(
    parameter  int WIDTH   = CHK_WIDTH,
    parameter  int NCHK    = CHK_NCHK,
    parameter  int TIMEOUT = CHK_TIMEOUT,
    localparam int IW      = (NCHK > 1) ? $clog2(NCHK) : 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_adr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_valid,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [IW-1:0]    fail_idx,
    output logic [WIDTH-1:0] fail_data
);

    chk_state_t       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    fidx_q, fidx_d;
    logic [WIDTH-1:0] fdata_q, fdata_d;

    chk_entry_t cur_entry;
    chk_entry_t wr_entry;
    logic       tbl_we;
    logic       nxt_valid;
    logic       head_valid;
    logic       head_valid_eff;
    logic       hit;
    logic       last;

    assign tbl_we   = cfg_we && (state_q != RUN);
    assign wr_entry = '{adr: cfg_adr, data: cfg_data, valid: cfg_valid};

    mips_chk_table #(
        .NCHK (NCHK),
        .IW   (IW)
    ) u_table (
        .clk_i        (clk),
        .rst_n_i      (reset),
        .we_i         (tbl_we),
        .widx_i       (cfg_idx),
        .wentry_i     (wr_entry),
        .rptr_i       (ptr_q),
        .rentry_o     (cur_entry),
        .nxt_valid_o  (nxt_valid),
        .head_valid_o (head_valid)
    );

    // A same-cycle write to entry 0 must decide whether start goes to RUN or PASS.
    assign head_valid_eff = (tbl_we && (cfg_idx == '0)) ? cfg_valid : head_valid;
    assign hit            = memwrite && (adr == cur_entry.adr);
    assign last           = (int'(ptr_q) == NCHK - 1) || !nxt_valid;

`ifdef MIPS_CHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fidx_d  = fidx_q;
        fdata_d = fdata_q;
`ifdef MIPS_CHK_TIMEOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            RUN: begin
                if (hit) begin
                    if (writedata == cur_entry.data) begin
                        if (last) begin
                            state_d = PASS;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end else begin
                        state_d = FAIL;
                        fidx_d  = ptr_q;
                        fdata_d = writedata;
                    end
                end
`ifdef MIPS_CHK_TIMEOUT_EN
                if (timer_q != TW'(TIMEOUT)) begin
                    timer_d = timer_q + 1'b1;
                end
                // A deciding write in the terminal cycle takes priority over the timeout.
                if ((state_d == RUN) && (timer_q == TW'(TIMEOUT - 1))) begin
                    state_d = TOUT;
                    fidx_d  = ptr_d;
                end
`endif
            end
            default: begin
                if (start) begin
                    state_d = head_valid_eff ? RUN : PASS;
                    ptr_d   = '0;
                    fidx_d  = '0;
                    fdata_d = '0;
`ifdef MIPS_CHK_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            fidx_q  <= '0;
            fdata_q <= '0;
`ifdef MIPS_CHK_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fidx_q  <= fidx_d;
            fdata_q <= fdata_d;
`ifdef MIPS_CHK_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign pass      = (state_q == PASS);
    assign fail      = (state_q == FAIL);
`ifdef MIPS_CHK_TIMEOUT_EN
    assign timeout   = (state_q == TOUT);
`else
    assign timeout   = 1'b0;
`endif
    assign done      = pass || fail || timeout;
    assign fail_idx  = fidx_q;
    assign fail_data = fdata_q;

endmodule

// File: tb/tb_mips_result_checker.sv
// Bench for mips_result_checker: directed scenarios plus randomized runs against a queue-based reference model.
module tb_mips_result_checker;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TO = 50;
`ifdef MIPS_CHK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         memwrite = 1'b0;
    logic [W-1:0] adr = '0;
    logic [W-1:0] writedata = '0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_idx = '0;
    logic [W-1:0] cfg_adr = '0;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_valid = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, pass, fail, timeout;
    logic [1:0]   fail_idx;
    logic [W-1:0] fail_data;

    always #5 clk = ~clk;

    mips_result_checker #(
        .WIDTH   (W),
        .NCHK    (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_adr   (cfg_adr),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .fail_idx  (fail_idx),
        .fail_data (fail_data)
    );

    int ncmp = 0;
    int nfail = 0;

    // Reference model: table contents, the queue of entry indices still expected,
    // the run outcome (0 idle, 1 running, 2 pass, 3 fail, 4 timeout) and RUN cycles elapsed.
    logic [W-1:0] ta [N];
    logic [W-1:0] td [N];
    bit           tv [N];
    int           pend [$];
    int           mst = 0;
    int           mt = 0;
    int           mfidx = 0;
    int           mfdata = 0;
    logic [W-1:0] pool [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            for (int i = 0; i < N; i++) tv[i] = 1'b0;
            pend.delete();
            mst = 0; mt = 0; mfidx = 0; mfdata = 0;
        end else if (mst == 1) begin
            if (memwrite && adr == ta[pend[0]]) begin
                if (writedata == td[pend[0]]) begin
                    void'(pend.pop_front());
                    if (pend.size() == 0) mst = 2;
                end else begin
                    mst = 3;
                    mfidx = pend[0];
                    mfdata = int'(writedata);
                end
            end
            if (mst == 1) begin
                mt++;
                if (TO_EN && mt == TO) begin
                    mst = 4;
                    mfidx = pend[0];
                end
            end
        end else begin
            if (cfg_we) begin
                ta[cfg_idx] = cfg_adr;
                td[cfg_idx] = cfg_data;
                tv[cfg_idx] = cfg_valid;
            end
            if (start) begin
                pend.delete();
                for (int i = 0; i < N && tv[i]; i++) pend.push_back(i);
                mfidx = 0; mfdata = 0; mt = 0;
                mst = (pend.size() == 0) ? 2 : 1;
            end
        end
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), 32'(mst == 1));
        chk("done", 32'(done), 32'(mst >= 2));
        chk("pass", 32'(pass), 32'(mst == 2));
        chk("fail", 32'(fail), 32'(mst == 3));
        chk("timeout", 32'(timeout), 32'(mst == 4));
        chk("fail_idx", 32'(fail_idx), 32'(mfidx));
        chk("fail_data", 32'(fail_data), 32'(mfdata));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        start = 1'b0;
        cfg_we = 1'b0;
        memwrite = 1'b0;
    endtask

    task automatic set_cfg(input int idx, input logic [W-1:0] a, input logic [W-1:0] d, input logic v);
        cfg_we = 1'b1;
        cfg_idx = 2'(idx);
        cfg_adr = a;
        cfg_data = d;
        cfg_valid = v;
    endtask

    task automatic set_wr(input logic [W-1:0] a, input logic [W-1:0] d);
        memwrite = 1'b1;
        adr = a;
        writedata = d;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin ta[i] = '0; td[i] = '0; tv[i] = 1'b0; end
        pool[0] = 8'h10; pool[1] = 8'h20; pool[2] = 8'hFF; pool[3] = 8'h33;

        // Reset state
        reset = 1'b0; step(); step();
        reset = 1'b1; step();
        chk("reset_done", 32'(done), 32'd0);

        // Fibonacci pass
        set_cfg(0, 8'hFF, 8'h0D, 1'b1); step();
        start = 1'b1; step();
        chk("fib_busy", 32'(busy), 32'd1);
        set_wr(8'hFF, 8'h0D); step();
        chk("fib_pass", 32'(pass), 32'd1);

        // Fibonacci fail, then a late correct write changes nothing
        start = 1'b1; step();
        set_wr(8'hFF, 8'h0C); step();
        chk("fib_fail", 32'(fail), 32'd1);
        chk("fib_fail_data", 32'(fail_data), 32'h0C);
        set_wr(8'hFF, 8'h0D); step();
        chk("fib_fail_sticky", 32'(fail), 32'd1);
        chk("fib_no_pass", 32'(pass), 32'd0);

        // Ordered two entries: early write for entry 1 is ignored
        set_cfg(0, 8'h10, 8'h01, 1'b1); step();
        set_cfg(1, 8'hFF, 8'h0D, 1'b1); step();
        set_cfg(2, 8'h00, 8'h00, 1'b0); step();
        start = 1'b1; step();
        set_wr(8'hFF, 8'h0D); step();
        chk("ord_still_busy", 32'(busy), 32'd1);
        set_wr(8'h10, 8'h01); step();
        chk("ord_mid_busy", 32'(busy), 32'd1);
        set_wr(8'hFF, 8'h0D); step();
        chk("ord_pass", 32'(pass), 32'd1);

        // Full table: pointer reaches the last entry without wrapping
        set_cfg(2, 8'h20, 8'h02, 1'b1); step();
        set_cfg(3, 8'h33, 8'h03, 1'b1); step();
        start = 1'b1; step();
        set_wr(8'h10, 8'h01); step();
        set_wr(8'hFF, 8'h0D); step();
        set_wr(8'h20, 8'h02); step();
        chk("full_busy", 32'(busy), 32'd1);
        set_wr(8'h33, 8'h04); step();
        chk("full_fail_idx", 32'(fail_idx), 32'd3);

        // Busy ignores configuration and restart
        set_cfg(1, 8'h00, 8'h00, 1'b0); step();
        set_cfg(0, 8'hFF, 8'h0D, 1'b1); step();
        start = 1'b1; step();
        set_cfg(0, 8'hFF, 8'h0E, 1'b1); start = 1'b1; step();
        chk("cfg_ignored_busy", 32'(busy), 32'd1);
        set_wr(8'hFF, 8'h0D); step();
        chk("cfg_ignored_pass", 32'(pass), 32'd1);

        // Table write and start together: entry 0 invalidated -> immediate pass
        set_cfg(0, 8'hFF, 8'h0D, 1'b0); start = 1'b1; step();
        chk("wr_start_pass", 32'(pass), 32'd1);

        // Reset mid-run with ptr=1
        set_cfg(0, 8'h10, 8'h01, 1'b1); step();
        set_cfg(1, 8'h20, 8'h02, 1'b1); step();
        start = 1'b1; step();
        set_wr(8'h10, 8'h01); step();
        reset = 1'b0; step();
        reset = 1'b1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        start = 1'b1; step();
        chk("rst_mid_pass", 32'(pass), 32'd1);

        // Timeout: no writes
        set_cfg(0, 8'hFF, 8'h0D, 1'b1); step();
        start = 1'b1; step();
        for (int c = 0; c < TO - 1; c++) step();
        chk("tout_before", 32'(timeout), 32'd0);
        step();
        chk("tout_at_limit", 32'(timeout), 32'(TO_EN));
        for (int c = 0; c < 5; c++) step();

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                set_cfg(i, pool[$urandom_range(0, 3)], W'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0));
                step();
            end
            start = 1'b1; step();
            for (int c = 0; c < 70; c++) begin
                if (mst == 1 && pend.size() > 0 && $urandom_range(0, 3) == 0) begin
                    set_wr(ta[pend[0]], td[pend[0]]);
                end else if ($urandom_range(0, 2) == 0) begin
                    set_wr(pool[$urandom_range(0, 3)], W'($urandom_range(0, 3)));
                end
                if ($urandom_range(0, 15) == 0) start = 1'b1;
                if ($urandom_range(0, 15) == 0) begin
                    set_cfg($urandom_range(0, 3), pool[$urandom_range(0, 3)], W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
